// File: rtl/dot_product_seq.sv
// Dot-product sequencer: streams len operand pairs from an operand buffer through one shared
// signed 8x8 multiplier, accumulates the products and hands the sum over with valid/ready.

module dot_product (
  input  logic signed [7:0]  i_a,
  input  logic signed [7:0]  i_b,
  output logic signed [16:0] o_p
);
  assign o_p = 17'(i_a) * 17'(i_b);
endmodule

module dot_product_seq #(
  parameter int MAX_LEN = 64,
  parameter int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W:0]           len,
  output logic                      busy,
  output logic                      len_err,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic signed [7:0]         a_data,
  input  logic signed [7:0]         b_data,
  output logic signed [16+ADDR_W:0] res,
  output logic                      res_valid,
  input  logic                      res_ready
);
  localparam int ACC_W = 17 + ADDR_W;
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                    r_state;
  logic                      r_busy;
  logic                      r_len_err;
  logic                      r_rd_en;
  logic [ADDR_W-1:0]         r_rd_addr;
  logic [ADDR_W-1:0]         r_last;
  logic                      r_dv;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   r_res;
  logic                      r_res_valid;

  logic signed [16:0]        w_prod;
  logic signed [ACC_W-1:0]   w_acc_next;

  dot_product u_mul (
    .i_a (a_data),
    .i_b (b_data),
    .o_p (w_prod)
  );

  // Operand data is only meaningful in the cycle after a read, which is when r_dv is set.
  assign w_acc_next = r_dv ? (r_acc + {{(ACC_W-17){w_prod[16]}}, w_prod}) : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_len_err   <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_last      <= '0;
      r_dv        <= 1'b0;
      r_acc       <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      r_dv      <= r_rd_en;
      r_acc     <= w_acc_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len > LEN_MAX) begin
              r_len_err <= 1'b1;
            end else if (len == '0) begin
              r_res       <= '0;
              r_res_valid <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_last    <= ADDR_W'(len - 1'b1);
              r_acc     <= '0;
              r_rd_en   <= 1'b1;
              r_rd_addr <= '0;
              r_busy    <= 1'b1;
              r_state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (r_rd_addr == r_last) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          // The final product lands in this same edge, so take the sum from the adder.
          r_res       <= w_acc_next;
          r_res_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign len_err   = r_len_err;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign res       = r_res;
  assign res_valid = r_res_valid;

endmodule

// File: doc/dot_product_seq.md
Name: dot_product_seq

Overview:
- Sequencer for one shared signed 8x8 multiplier (`dot_product`, 17-bit product).
- On a start command it fetches `len` operand pairs from an operand buffer, one pair per cycle.
- It drives each pair through the multiplier and accumulates the products into a vector dot-product result.
- It sits between the operand SRAMs and the layer-level control that consumes results with a valid/ready handshake.

Parameters:
- MAX_LEN, 64, maximum vector length per command. Must be a power of two, ≥ 2.
- ADDR_W, $clog2(MAX_LEN), operand buffer address width.
- ACC_W (localparam), 17+ADDR_W, accumulator/result width. Overflow is impossible for any legal length.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  command strobe, sampled only in IDLE.
- len  in  ADDR_W+1  vector length for the command, 0..MAX_LEN.
- busy  out  1  high in every state except IDLE.
- len_err  out  1  one-cycle pulse: start seen with len > MAX_LEN.
- rd_en  out  1  operand read request.
- rd_addr  out  ADDR_W  element index of the read.
- a_data  in  8  signed operand A, valid exactly 1 cycle after rd_en.
- b_data  in  8  signed operand B, valid exactly 1 cycle after rd_en.
- res  out  ACC_W  signed dot-product result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - state=IDLE;
  - busy, len_err, rd_en, res_valid = 0;
  - rd_addr=0, res=0;
  - accumulator and counters = 0;
  - the read-data-valid pipeline flag = 0.
- Reset mid-command aborts it: data returning after reset is discarded and no result is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with 1 ≤ len ≤ MAX_LEN: latch len, clear accumulator, go to RUN.
  - start=1 with len=0: res=0, go directly to DONE.
  - start=1 with len > MAX_LEN: len_err=1 for one cycle, stay in IDLE.
  - start while not IDLE is ignored, with no error.
- RUN:
  - rd_en=1 every cycle; rd_addr = issue count 0,1,…,len-1.
  - After issuing len-1, go to DRAIN.
  - No stalls: exactly len consecutive rd_en cycles.
- Data pipeline:
  - A registered flag `dv` = rd_en delayed by 1 cycle.
  - When dv=1, acc <= acc + sign_extend(a_data*b_data) at that edge.
  - The product comes from an instantiated `dot_product`, 17-bit signed, sign-extended to ACC_W.
- DRAIN:
  - rd_en=0; the last product accumulates this cycle.
  - Then res <= final acc value, go to DONE.
- DONE:
  - res_valid=1; res stable until handshake.
  - res_valid & res_ready at an edge: go to IDLE, res_valid=0 on the next cycle.
  - res_ready while res_valid=0 has no effect.
- Latency: start accepted at edge T; rd_en high cycles T+1..T+len; res_valid first high at T+len+2 (len≥1); T+1 for len=0.
- Throughput: with res_ready tied high, back-to-back commands need len+3 cycles each (one IDLE cycle between).
- Arithmetic:
  - Fully signed two's complement, no saturation.
  - Worst case len=MAX_LEN with all products +16384 (-128*-128) gives 2^20 at default, which fits in ACC_W=23 signed.
- rd_addr holds its last value when rd_en=0. Consumers must not rely on it.

Test Plan:
- len=4, A={1,2,3,4}, B={5,6,7,8}:
  - rd_en high 4 consecutive cycles, rd_addr 0..3.
  - res=70, res_valid at start+6.
  - busy high from start+1 until handshake.
- len=MAX_LEN=64, all A=B=-128 -> res=1048576 with no wrap. Repeat with A=-128, B=127 -> res=-1040384.
- len=0 -> no rd_en, res_valid at start+1 with res=0. Then len=65 -> len_err single pulse, busy stays 0, no reads.
- Backpressure: len=3, A={-1,-1,-1}, B={2,2,2}; hold res_ready=0 for 10 cycles:
  - res=-6 held stable with res_valid=1;
  - start pulses during the hold are ignored.
  - Then res_ready=1 -> IDLE next cycle.
- Reset mid-RUN: len=8, assert rst at the 3rd rd_en cycle:
  - next cycle all outputs at reset values, no res_valid;
  - a fresh len=2 command, A={3,4}, B={5,6} -> res=39.
- Back-to-back with res_ready tied 1: two len=2 commands, the second started in the IDLE cycle after the first result:
  - results correct, accumulator cleared between commands;
  - spacing 5 cycles per command.
